// File: rtl/ram_word_unpacker_if.sv
// rtl/ram_word_unpacker_if.sv - command, RAM read port, byte stream and status bundle for ram_word_unpacker
interface ram_word_unpacker_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 5
) ();
    logic                    start;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [ADDR_WIDTH:0]     word_count;
    logic                    abort;
    logic [ADDR_WIDTH-1:0]   rdaddress;
    logic [DATA_WIDTH*8-1:0] ram_q;
    logic [7:0]              byte_out;
    logic                    byte_valid;
    logic                    byte_ready;
    logic                    byte_last;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, start_addr, word_count, abort, ram_q, byte_ready,
        output rdaddress, byte_out, byte_valid, byte_last, busy, done
    );

    modport slave (
        output start, start_addr, word_count, abort, ram_q, byte_ready,
        input  rdaddress, byte_out, byte_valid, byte_last, busy, done
    );
endinterface

// File: rtl/ram_word_unpacker.sv
// rtl/ram_word_unpacker.sv - reads RAM words and emits their bytes LSB lane first
module ram_word_unpacker #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    ram_word_unpacker_if.master bus
);
    localparam int WORD_BITS = DATA_WIDTH * 8;
    localparam int LANE_BITS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [LANE_BITS-1:0]  TOP_LANE = LANE_BITS'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_WORD = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] rdaddress;
    logic [WORD_BITS-1:0]  shift;
    logic [LANE_BITS-1:0]  lane;
    logic                  shift_valid;
    logic [WORD_BITS-1:0]  hold;
    logic                  hold_valid;
    // issued: rdaddress presents a new read this cycle; due: its data is on ram_q this cycle
    logic                  issued;
    logic                  due;
    // words not yet loaded into the shift register, including the one in flight or held
    logic [ADDR_WIDTH:0]   words_remaining;

    logic accept;
    logic need_word;
    logic launch;
    logic load_hold;
    logic load_q;
    logic fill_hold;
    logic issue_next;
    logic final_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        accept       = shift_valid && bus.byte_ready;
        need_word    = 1'b0;
        launch       = 1'b0;
        load_hold    = 1'b0;
        load_q       = 1'b0;
        fill_hold    = 1'b0;
        issue_next   = 1'b0;
        final_accept = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.word_count == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = RUN;
                        launch     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    need_word    = !shift_valid || (accept && lane == '0);
                    // the held word is older than anything on ram_q, so it goes first
                    load_hold    = need_word && hold_valid;
                    load_q       = need_word && !hold_valid && due;
                    fill_hold    = due && !load_q;
                    // prefetch only on a shift load, which keeps one read in flight at most
                    issue_next   = (load_hold || load_q) && (words_remaining > ONE_WORD);
                    final_accept = accept && lane == '0 && words_remaining == '0;
                    if (final_accept) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdaddress       <= '0;
            shift           <= '0;
            lane            <= '0;
            shift_valid     <= 1'b0;
            hold            <= '0;
            hold_valid      <= 1'b0;
            issued          <= 1'b0;
            due             <= 1'b0;
            words_remaining <= '0;
        end else begin
            due <= issued;
            if (launch) begin
                rdaddress       <= bus.start_addr;
                issued          <= 1'b1;
                words_remaining <= bus.word_count;
                shift_valid     <= 1'b0;
                hold_valid      <= 1'b0;
            end else if (state == RUN && bus.abort) begin
                issued          <= 1'b0;
                due             <= 1'b0;
                shift_valid     <= 1'b0;
                hold_valid      <= 1'b0;
                words_remaining <= '0;
            end else if (state == RUN) begin
                issued <= issue_next;
                if (issue_next) begin
                    rdaddress <= rdaddress + ADDR_ONE;
                end
                if (load_hold || load_q) begin
                    shift           <= load_hold ? hold : bus.ram_q;
                    lane            <= TOP_LANE;
                    shift_valid     <= 1'b1;
                    words_remaining <= words_remaining - ONE_WORD;
                end else if (accept) begin
                    if (lane == '0) begin
                        shift_valid <= 1'b0;
                    end else begin
                        shift <= shift >> 8;
                        lane  <= lane - 1'b1;
                    end
                end
                if (load_hold) begin
                    hold_valid <= 1'b0;
                end
                if (fill_hold) begin
                    hold       <= bus.ram_q;
                    hold_valid <= 1'b1;
                end
            end else begin
                issued <= 1'b0;
            end
        end
    end

    assign bus.rdaddress  = rdaddress;
    assign bus.byte_out   = shift[7:0];
    assign bus.byte_valid = shift_valid;
    assign bus.byte_last  = shift_valid && lane == '0 && words_remaining == '0;
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == FINISH);
endmodule
